// File: rtl/hazard_pkg.sv
// Shared constants, FSM encoding and register-compare helpers for the hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } multState_t;

    // $zero is hardwired, so a write to it can never create a dependency
    function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

    // M has the freshest value, so it wins over W when both target the same register
    function automatic logic [1:0] fwdSel(
        input logic [REG_W-1:0] src,
        input logic             regwriteM,
        input logic [REG_W-1:0] writeRegM,
        input logic             regwriteW,
        input logic [REG_W-1:0] writeRegW
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (regwriteM && regMatch(writeRegM, src)) begin
            sel = FWD_MEM;
        end else if (regwriteW && regMatch(writeRegW, src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_mult_seq.sv
// Multi-cycle EX sequencer: holds E for MULT_LAT cycles total, asserting MultBusy for all but the last.
module hazard_mult_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MultStartE,
    output logic MultBusy
);

    localparam bit          MULTI_CYCLE = (MULT_LAT > 32'd1);
    localparam int unsigned LOAD_VAL    = MULTI_CYCLE ? (MULT_LAT - 32'd2) : 32'd0;
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VAL);

    multState_t       state;
    logic [CNT_W-1:0] cnt;

    // MultStartE is ignored while BUSY: in the cnt==0 cycle the op is leaving E
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MultStartE && MULTI_CYCLE) begin
                        state <= ST_BUSY;
                        cnt   <= LOAD_CNT;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        MultBusy = 1'b0;
        if (rst_n) begin
            if (state == ST_BUSY) begin
                MultBusy = (cnt != '0);
            end else begin
                MultBusy = MultStartE && MULTI_CYCLE;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use/branch stalls, multi-cycle EX holds.
// Optional HAZARD_STATS_EN adds free-running stall and flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegwriteE,
    input  logic             RegwriteM,
    input  logic             RegwriteW,
    input  logic             MemtoregE,
    input  logic             MemtoregM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             MultStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             StallE,
    output logic             FlushM,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MultBusy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      StallCnt,
    output logic [31:0]      FlushCnt
`endif
);

    logic multBusy;
    logic lwStall;
    logic branchStall;
    logic anyStall;

    hazard_mult_seq #(
        .MULT_LAT (MULT_LAT),
        .CNT_W    (CNT_W)
    ) u_mult_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .MultStartE (MultStartE),
        .MultBusy   (multBusy)
    );

    // Load in E feeding either D operand, or branch compare needing a value not yet in M/W
    always_comb begin
        lwStall = MemtoregE && (regMatch(rtE, rsD) || regMatch(rtE, rtD));
        branchStall = BranchD &&
            ((RegwriteE && (regMatch(WriteRegE, rsD) || regMatch(WriteRegE, rtD))) ||
             (MemtoregM && (regMatch(WriteRegM, rsD) || regMatch(WriteRegM, rtD))));
        anyStall = lwStall || branchStall || multBusy;
    end

    // Everything is forced low while reset is held; E is held rather than cleared while busy
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        StallE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        MultBusy  = 1'b0;
        if (rst_n) begin
            StallF    = anyStall;
            StallD    = anyStall;
            StallE    = multBusy;
            FlushM    = multBusy;
            FlushE    = (lwStall || branchStall) && !multBusy;
            FlushD    = (PCSrcD || JumpD) && !anyStall;
            ForwardAD = RegwriteM && regMatch(WriteRegM, rsD);
            ForwardBD = RegwriteM && regMatch(WriteRegM, rtD);
            ForwardAE = fwdSel(rsE, RegwriteM, WriteRegM, RegwriteW, WriteRegW);
            ForwardBE = fwdSel(rtE, RegwriteM, WriteRegM, RegwriteW, WriteRegW);
            MultBusy  = multBusy;
        end
    end

`ifdef HAZARD_STATS_EN
    // Event counters wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (FlushE || FlushD) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes reference-model expectations, negedge monitor checks.
module tb_hazard_ctrl;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegwriteE, RegwriteM, RegwriteW, MemtoregE, MemtoregM;
    logic       BranchD, PCSrcD, JumpD, MultStartE;

    logic       StallF, StallD, FlushD, FlushE, StallE, FlushM, ForwardAD, ForwardBD, MultBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic       o1StallF, o1StallD, o1FlushD, o1FlushE, o1StallE, o1FlushM, o1FwdAD, o1FwdBD, o1Busy;
    logic [1:0] o1FwdAE, o1FwdBE;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCnt, FlushCnt, o1StallCnt, o1FlushCnt;
`endif

    hazard_ctrl #(.MULT_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegwriteE(RegwriteE), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
        .MemtoregE(MemtoregE), .MemtoregM(MemtoregM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .MultStartE(MultStartE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallE(StallE), .FlushM(FlushM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MultBusy(MultBusy)
`ifdef HAZARD_STATS_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    // Single-cycle configuration: must never report busy
    hazard_ctrl #(.MULT_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegwriteE(RegwriteE), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
        .MemtoregE(MemtoregE), .MemtoregM(MemtoregM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .MultStartE(MultStartE),
        .StallF(o1StallF), .StallD(o1StallD), .FlushD(o1FlushD), .FlushE(o1FlushE),
        .StallE(o1StallE), .FlushM(o1FlushM), .ForwardAD(o1FwdAD), .ForwardBD(o1FwdBD),
        .ForwardAE(o1FwdAE), .ForwardBE(o1FwdBE), .MultBusy(o1Busy)
`ifdef HAZARD_STATS_EN
        , .StallCnt(o1StallCnt), .FlushCnt(o1FlushCnt)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, pcs, jmp, ms;
    } stim_t;

    typedef struct {
        logic [1:0]  fAE, fBE;
        logic        fAD, fBD, stF, stD, flD, flE, stE, flM, busy;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t        q[$];
    stim_t       s;
    int          tests = 0;
    int          fails = 0;
    int          age = 0;
    int unsigned mStall = 0;
    int unsigned mFlush = 0;

    function automatic stim_t idleStim();
        stim_t t;
        t = '{default: 0};
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic bit m(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdE(input stim_t t, input logic [4:0] r);
        if (t.rwM && m(t.wrM, r)) return 2'd2;
        if (t.rwW && m(t.wrW, r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
        end
    endtask

    // Apply the staged stimulus just after a rising edge and queue what the spec predicts
    task automatic issue();
        exp_t e;
        bit   lw, br, busy, stall, fE, fD;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        WriteRegE = s.wrE; WriteRegM = s.wrM; WriteRegW = s.wrW;
        RegwriteE = s.rwE; RegwriteM = s.rwM; RegwriteW = s.rwW;
        MemtoregE = s.mtrE; MemtoregM = s.mtrM; BranchD = s.brD;
        PCSrcD = s.pcs; JumpD = s.jmp; MultStartE = s.ms;

        e = '{default: 0};
        lw = 0; br = 0; busy = 0; stall = 0; fE = 0; fD = 0;
        if (s.rst_n) begin
            // age = cycles the current multi-cycle op has already spent in E
            if (age == 0) busy = s.ms && (LAT > 1);
            else          busy = (age + 1) < int'(LAT);
            lw = s.mtrE && (m(s.rtE, s.rsD) || m(s.rtE, s.rtD));
            br = s.brD && ((s.rwE && (m(s.wrE, s.rsD) || m(s.wrE, s.rtD))) ||
                           (s.mtrM && (m(s.wrM, s.rsD) || m(s.wrM, s.rtD))));
            stall = lw || br || busy;
            fE = (lw || br) && !busy;
            fD = (s.pcs || s.jmp) && !stall;
            e.stF = stall; e.stD = stall; e.stE = busy; e.flM = busy;
            e.flE = fE; e.flD = fD; e.busy = busy;
            e.fAD = s.rwM && m(s.wrM, s.rsD);
            e.fBD = s.rwM && m(s.wrM, s.rtD);
            e.fAE = fwdE(s, s.rsE);
            e.fBE = fwdE(s, s.rtE);
        end
        e.sc = mStall;
        e.fc = mFlush;
        q.push_back(e);

        if (!s.rst_n) begin
            age = 0; mStall = 0; mFlush = 0;
        end else begin
            age = busy ? age + 1 : 0;
            if (stall) mStall++;
            if (fE || fD) mFlush++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("StallF", 32'(StallF), 32'(e.stF));
                chk("StallD", 32'(StallD), 32'(e.stD));
                chk("FlushD", 32'(FlushD), 32'(e.flD));
                chk("FlushE", 32'(FlushE), 32'(e.flE));
                chk("StallE", 32'(StallE), 32'(e.stE));
                chk("FlushM", 32'(FlushM), 32'(e.flM));
                chk("MultBusy", 32'(MultBusy), 32'(e.busy));
                chk("ForwardAD", 32'(ForwardAD), 32'(e.fAD));
                chk("ForwardBD", 32'(ForwardBD), 32'(e.fBD));
                chk("ForwardAE", 32'(ForwardAE), 32'(e.fAE));
                chk("ForwardBE", 32'(ForwardBE), 32'(e.fBE));
                chk("MultBusy_lat1", 32'(o1Busy), 32'd0);
                chk("StallE_lat1", 32'(o1StallE), 32'd0);
`ifdef HAZARD_STATS_EN
                chk("StallCnt", StallCnt, e.sc);
                chk("FlushCnt", FlushCnt, e.fc);
`endif
            end
        end
    end

    initial begin : driver
        s = idleStim();
        s.rst_n = 1'b0;
        issue();
        issue();
        s.rst_n = 1'b1;
        issue();

        // forwarding priority
        s.rwM = 1; s.wrM = 5'd8; s.rwW = 1; s.wrW = 5'd8; s.rsE = 5'd8; s.rtE = 5'd8;
        issue();
        s.rwM = 0;
        issue();
        s.wrM = 5'd0; s.wrW = 5'd0; s.rsE = 5'd0; s.rtE = 5'd0; s.rwM = 1;
        issue();

        // load-use, then register 0 never matches
        s = idleStim();
        s.mtrE = 1; s.rtE = 5'd9; s.rsD = 5'd9;
        issue();
        s.rtE = 5'd0; s.rsD = 5'd0;
        issue();

        // branch hazard with a taken branch in the same cycle
        s = idleStim();
        s.brD = 1; s.rwE = 1; s.wrE = 5'd5; s.rtD = 5'd5; s.pcs = 1;
        issue();
        s.rwE = 0; s.mtrM = 1; s.wrM = 5'd5;
        issue();
        s = idleStim();
        s.jmp = 1;
        issue();

        // multi-cycle op held back to back
        s = idleStim();
        s.ms = 1;
        repeat (10) issue();
        s.ms = 0;
        repeat (3) issue();

        // busy beats load-use
        s.ms = 1;
        issue();
        s.mtrE = 1; s.rtE = 5'd9; s.rsD = 5'd9; s.jmp = 1;
        issue();
        s = idleStim();
        repeat (3) issue();

        // reset on the second busy cycle drops the pending stall
        s.ms = 1;
        issue();
        s.rst_n = 0;
        issue();
        s.rst_n = 1; s.ms = 0;
        repeat (3) issue();

        // three stalled cycles plus one flush for the counters
        s = idleStim(); s.rst_n = 0;
        issue();
        s.rst_n = 1; s.ms = 1;
        issue();
        s.ms = 0;
        repeat (3) issue();
        s.jmp = 1;
        issue();
        s.jmp = 0;
        repeat (2) issue();
        s.rst_n = 0;
        issue();
        s.rst_n = 1;
        issue();

        // randomized traffic on a small register range so dependencies are frequent
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 80) != 0);
            s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
            s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
            s.wrE = 5'($urandom_range(0, 3)); s.wrM = 5'($urandom_range(0, 3));
            s.wrW = 5'($urandom_range(0, 3));
            s.rwE = 1'($urandom_range(0, 1)); s.rwM = 1'($urandom_range(0, 1));
            s.rwW = 1'($urandom_range(0, 1)); s.mtrE = 1'($urandom_range(0, 1));
            s.mtrM = 1'($urandom_range(0, 1)); s.brD = 1'($urandom_range(0, 1));
            s.pcs = 1'($urandom_range(0, 1)); s.jmp = ($urandom_range(0, 3) == 0);
            s.ms = ($urandom_range(0, 3) == 0);
            issue();
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
